mem_store_buffer: RTL and testbench
===================================

Name: mem_store_buffer

Overview:
- Sits in the MEM stage, directly upstream of the byte-enabled data memory (32-bit word RAM, 4-bit byte write enable, writes on negedge clk).
- Accepts committed stores (SB/SH/SW/SWL/SWR), aligns store data to byte lanes and generates the 4-bit write enable.
- Queues aligned stores in a small FIFO and drains one per cycle when the memory port is granted.
- Flags loads that hit a pending store word so the pipeline can stall.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, >=2)
PTR_W, 2, log2(DEPTH)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous active-high reset
st_valid  in  1  store request valid
st_ready  out  1  buffer can accept (= !full)
st_op  in  3  0 SB, 1 SH, 2 SW, 3 SWL, 4 SWR, 5-7 reserved
st_addr  in  32  byte address
st_data  in  32  rt register value, unaligned
st_misaligned  out  1  registered one-cycle pulse: rejected misaligned store
mem_grant  in  1  data memory port free this cycle
mem_addr  out  32  head entry address, word aligned ([1:0]=0)
mem_data  out  32  head entry lane-aligned data
mem_we  out  4  byte enables to memory; we[3] = bits[31:24]
ld_addr  in  32  address of load in MEM stage
ld_conflict  out  1  a valid entry matches ld_addr[31:2]
count  out  PTR_W+1  occupancy

Behaviour:
- Big-endian lanes: byte offset k = addr[1:0] maps to data bits [31-8k:24-8k], enable bit 3-k.
- SB: data = {4{rt[7:0]}}; we = 4'b1000 >> k.
- SH: k=0 gives {rt[15:0],16'b0} with we 1100; k=2 gives {16'b0,rt[15:0]} with we 0011; k odd is misaligned.
- SW: k=0 gives rt with we 1111; k!=0 is misaligned.
- SWL: data = rt >> 8k; we = 4'b1111 >> k.
- SWR: data = rt << 8(3-k); we = (4'b1111 << (3-k)) & 4'b1111.
- Push occurs when st_valid && st_ready at posedge:
  - The aligned entry {addr[31:2], data, we} is written at the tail.
  - Misaligned or reserved ops are consumed (not queued).
  - For misaligned ops only, st_misaligned is 1 for the following cycle.
- Outputs:
  - mem_we = (!empty && mem_grant) ? head.we : 4'b0, combinational.
  - mem_addr and mem_data always show the head entry, or 0 when empty.
- Pop occurs at posedge when !empty && mem_grant. Memory captures the write on the negedge inside that cycle.
- Latency: a store accepted at edge N drives mem_we at the earliest in cycle N..N+1 and is popped at edge N+1.
- st_ready = !full. Pop in the same cycle does not free a slot for that cycle's push (no full-bypass).
- Simultaneous push and pop when neither empty nor full: both happen and count is unchanged.
- Empty with push and mem_grant: no bypass. The entry is written and drained the next cycle.
- Pointers wrap modulo DEPTH. count goes 0..DEPTH.
- ld_conflict: combinational OR over valid entries of (entry.addr[31:2] == ld_addr[31:2]). A store being pushed in the same cycle is not included.
- Reset (async, any time):
  - All entries invalid; pointers and count 0; mem_we 0; mem_addr and mem_data 0; st_misaligned 0; ld_conflict 0.
  - Pending stores are discarded.

Optional Feature:
STBUF_MERGE_EN
- Defined: on push, if the youngest valid entry has the same addr[31:2] and is not being popped this cycle, the new store is merged into it instead of allocated:
  - bytes with new we bit set are overwritten;
  - we becomes the OR of old and new;
  - count is unchanged.
- Merge is allowed even when full, so st_ready = !full || merge_possible.
- Not defined: every accepted valid store allocates a new entry.

Test Plan:
- SB rt=0x000000A5 at addr 0x101 with grant=1 -> next cycle mem_addr=0x100, mem_data=0xA5A5A5A5, mem_we=0100; following cycle count=0.
- SWL rt=0x11223344 at 0x202, then SWR rt=0x55667788 at 0x202 -> entries {0x00001122, we 0011} then {0x66778800, we 1110}, drained in order.
- SH at 0x303 -> st_misaligned pulses 1 for one cycle, count stays 0, mem_we stays 0.
- grant=0, push 4 SW to 0x0, 0x4, 0x8, 0xC -> st_ready=0 after 4th; ld_addr=0x9 gives ld_conflict=1, ld_addr=0x10 gives 0. Raise grant -> drains 0x0, 0x4, 0x8, 0xC on 4 consecutive cycles.
- Assert rst mid-drain with count=3 -> immediately count=0, mem_we=0, st_ready=1.
- STBUF_MERGE_EN, grant=0: SB 0xAA at 0x40 then SB 0xBB at 0x41 -> count=1, entry {0xAABB0000 (upper bytes), we 1100}. Without the macro -> count=2.

Source files
------------

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: aligns SB/SH/SW/SWL/SWR stores to big-endian byte lanes, queues them and drains one per granted cycle.
// Optional STBUF_MERGE_EN: a store to the youngest pending word merges into that entry instead of allocating a new one.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [2:0]       st_op,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             st_misaligned,
  input  logic             mem_grant,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_data,
  output logic [3:0]       mem_we,
  input  logic [31:0]      ld_addr,
  output logic             ld_conflict,
  output logic [PTR_W:0]   count
);

  logic [29:0]      addr_reg [DEPTH];
  logic [31:0]      data_reg [DEPTH];
  logic [3:0]       we_reg   [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [PTR_W:0]   count_reg, count_next;
  logic             mis_reg;

  logic [1:0]  k;
  logic [31:0] al_data;
  logic [3:0]  al_we;
  logic        al_ok, al_bad;

  always_comb begin
    k       = st_addr[1:0];
    al_data = 32'h0;
    al_we   = 4'h0;
    al_ok   = 1'b0;
    al_bad  = 1'b0;
    case (st_op)
      3'd0: begin
        al_data = {4{st_data[7:0]}};
        al_we   = 4'b1000 >> k;
        al_ok   = 1'b1;
      end
      3'd1: begin
        if (k == 2'd0) begin
          al_data = {st_data[15:0], 16'h0};
          al_we   = 4'b1100;
          al_ok   = 1'b1;
        end else if (k == 2'd2) begin
          al_data = {16'h0, st_data[15:0]};
          al_we   = 4'b0011;
          al_ok   = 1'b1;
        end else begin
          al_bad  = 1'b1;
        end
      end
      3'd2: begin
        if (k == 2'd0) begin
          al_data = st_data;
          al_we   = 4'b1111;
          al_ok   = 1'b1;
        end else begin
          al_bad  = 1'b1;
        end
      end
      3'd3: begin
        al_data = st_data >> {k, 3'b000};
        al_we   = 4'b1111 >> k;
        al_ok   = 1'b1;
      end
      3'd4: begin
        // ~k is 3-k for a 2-bit offset
        al_data = st_data << {~k, 3'b000};
        al_we   = 4'b1111 << ~k;
        al_ok   = 1'b1;
      end
      default: ;
    endcase
  end

  logic empty, full, pop, push, alloc, merge_possible, merge;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (PTR_W+1)'(DEPTH));
  assign pop   = !empty && mem_grant;

`ifdef STBUF_MERGE_EN
  logic [PTR_W-1:0] young_idx;
  assign young_idx = tail_reg - PTR_W'(1);
  // The youngest entry cannot absorb a store while it is leaving the buffer.
  assign merge_possible = !empty && (addr_reg[young_idx] == st_addr[31:2])
                          && !(pop && count_reg == (PTR_W+1)'(1));
  assign st_ready = !full || merge_possible;
`else
  assign merge_possible = 1'b0;
  assign st_ready = !full;
`endif

  assign push  = st_valid && st_ready;
  assign alloc = push && al_ok && !merge_possible;
  assign merge = push && al_ok && merge_possible;

  always_comb begin
    count_next = count_reg;
    case ({alloc, pop})
      2'b10:   count_next = count_reg + (PTR_W+1)'(1);
      2'b01:   count_next = count_reg - (PTR_W+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_reg[i] <= '0;
        data_reg[i] <= '0;
        we_reg[i]   <= '0;
      end
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      mis_reg   <= 1'b0;
    end else begin
      mis_reg   <= push && al_bad;
      count_reg <= count_next;
      if (pop) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + PTR_W'(1);
      end
      if (alloc) begin
        addr_reg[tail_reg]  <= st_addr[31:2];
        data_reg[tail_reg]  <= al_data;
        we_reg[tail_reg]    <= al_we;
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_reg + PTR_W'(1);
      end
`ifdef STBUF_MERGE_EN
      if (merge) begin
        for (int b = 0; b < 4; b++) begin
          if (al_we[b]) data_reg[young_idx][8*b +: 8] <= al_data[8*b +: 8];
        end
        we_reg[young_idx] <= we_reg[young_idx] | al_we;
      end
`endif
    end
  end

  logic [DEPTH-1:0] hit;
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit[gi] = valid_reg[gi] && (addr_reg[gi] == ld_addr[31:2]);
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = ^{ld_addr[1:0], merge};

  assign ld_conflict   = |hit;
  assign mem_addr      = empty ? 32'h0 : {addr_reg[head_reg], 2'b00};
  assign mem_data      = empty ? 32'h0 : data_reg[head_reg];
  assign mem_we        = pop ? we_reg[head_reg] : 4'h0;
  assign st_misaligned = mis_reg;
  assign count         = count_reg;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer: alignment vector table, scoreboard on the memory write port, and hand-written FIFO sequences.
module tb_mem_store_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid, st_ready, st_misaligned, mem_grant, ld_conflict;
  logic [2:0]  st_op;
  logic [31:0] st_addr, st_data, mem_addr, mem_data, ld_addr;
  logic [3:0]  mem_we;
  logic [2:0]  count;

  mem_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
    .st_misaligned(st_misaligned), .mem_grant(mem_grant),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  we;
  } ent_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [3:0]  ewe;
    logic        emis;
    logic        qd;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  ent_t sb_q[$];
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic expect_ent(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    ent_t e;
    e.a = a; e.d = d; e.we = we;
    sb_q.push_back(e);
  endtask

  // Memory captures on negedge; every enabled write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && mem_we != 4'h0) begin
      if (sb_q.size() == 0) begin
        check("drain_unexpected_we", {28'h0, mem_we}, 32'h0);
      end else begin
        ent_t e;
        e = sb_q.pop_front();
        check("drain_addr", mem_addr, e.a);
        check("drain_data", mem_data, e.d);
        check("drain_we", {28'h0, mem_we}, {28'h0, e.we});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd0, 32'h101, 32'h000000A5, 32'h100, 32'hA5A5A5A5, 4'b0100, 1'b0, 1'b1};
    vecs[1]  = '{3'd0, 32'h103, 32'h12345678, 32'h100, 32'h78787878, 4'b0001, 1'b0, 1'b1};
    vecs[2]  = '{3'd1, 32'h200, 32'hABCD1234, 32'h200, 32'h12340000, 4'b1100, 1'b0, 1'b1};
    vecs[3]  = '{3'd1, 32'h202, 32'hABCD1234, 32'h200, 32'h00001234, 4'b0011, 1'b0, 1'b1};
    vecs[4]  = '{3'd1, 32'h303, 32'hABCD1234, 32'h0,   32'h0,        4'b0000, 1'b1, 1'b0};
    vecs[5]  = '{3'd2, 32'h400, 32'hDEADBEEF, 32'h400, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b1};
    vecs[6]  = '{3'd2, 32'h402, 32'hDEADBEEF, 32'h0,   32'h0,        4'b0000, 1'b1, 1'b0};
    vecs[7]  = '{3'd3, 32'h202, 32'h11223344, 32'h200, 32'h00001122, 4'b0011, 1'b0, 1'b1};
    vecs[8]  = '{3'd4, 32'h202, 32'h55667788, 32'h200, 32'h66778800, 4'b1110, 1'b0, 1'b1};
    vecs[9]  = '{3'd3, 32'h500, 32'hCAFEF00D, 32'h500, 32'hCAFEF00D, 4'b1111, 1'b0, 1'b1};
    vecs[10] = '{3'd4, 32'h503, 32'hCAFEF00D, 32'h500, 32'hCAFEF00D, 4'b1111, 1'b0, 1'b1};
    vecs[11] = '{3'd3, 32'h503, 32'hCAFEF00D, 32'h500, 32'h000000CA, 4'b0001, 1'b0, 1'b1};
    vecs[12] = '{3'd4, 32'h500, 32'hCAFEF00D, 32'h500, 32'h0D000000, 4'b1000, 1'b0, 1'b1};
    vecs[13] = '{3'd5, 32'h600, 32'h01020304, 32'h0,   32'h0,        4'b0000, 1'b0, 1'b0};

    st_valid = 1'b0; st_op = 3'd0; st_addr = 32'h0; st_data = 32'h0;
    mem_grant = 1'b0; ld_addr = 32'h0;

    #1;
    check("reset_count", {29'h0, count}, 32'd0);
    check("reset_mem_we", {28'h0, mem_we}, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_data", mem_data, 32'h0);
    check("reset_misaligned", {31'h0, st_misaligned}, 32'h0);
    check("reset_ld_conflict", {31'h0, ld_conflict}, 32'h0);
    check("reset_st_ready", {31'h0, st_ready}, 32'h1);
    step();
    rst = 1'b0;
    step();

    // Alignment table, drained immediately with grant held high.
    mem_grant = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, vecs[i].addr, vecs[i].data);
      if (vecs[i].qd) expect_ent(vecs[i].ea, vecs[i].ed, vecs[i].ewe);
      step();
      st_valid = 1'b0;
      check($sformatf("vec%0d_misaligned", i), {31'h0, st_misaligned}, {31'h0, vecs[i].emis});
      check($sformatf("vec%0d_count", i), {29'h0, count}, {31'h0, vecs[i].qd});
      step();
      check($sformatf("vec%0d_count_drained", i), {29'h0, count}, 32'd0);
      check($sformatf("vec%0d_misaligned_end", i), {31'h0, st_misaligned}, 32'h0);
      step();
    end

    // Fill to full with grant low, probe conflicts, then drain in order.
    mem_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3'd2, 32'(4 * i), 32'h1000 + 32'(i));
      if (i == 0) begin
        ld_addr = 32'h0;
        #1;
        check("conflict_excludes_push", {31'h0, ld_conflict}, 32'h0);
      end
      expect_ent(32'(4 * i), 32'h1000 + 32'(i), 4'b1111);
      step();
    end
    st_valid = 1'b0;
    check("full_count", {29'h0, count}, 32'd4);
    check("full_st_ready", {31'h0, st_ready}, 32'h0);
    drive(3'd2, 32'h20, 32'hFFFFFFFF);
    step();
    st_valid = 1'b0;
    check("full_push_ignored", {29'h0, count}, 32'd4);
    ld_addr = 32'h9;
    #1;
    check("conflict_hit", {31'h0, ld_conflict}, 32'h1);
    ld_addr = 32'h10;
    #1;
    check("conflict_miss", {31'h0, ld_conflict}, 32'h0);
    mem_grant = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      step();
      check($sformatf("drain_count_%0d", i), {29'h0, count}, 32'(i));
    end
    check("drained_st_ready", {31'h0, st_ready}, 32'h1);

    // Simultaneous push and pop keeps count steady.
    mem_grant = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(3'd2, 32'h800 + 32'(4 * i), 32'hA0 + 32'(i));
      expect_ent(32'h800 + 32'(4 * i), 32'hA0 + 32'(i), 4'b1111);
      step();
    end
    mem_grant = 1'b1;
    drive(3'd2, 32'h808, 32'hA2);
    expect_ent(32'h808, 32'hA2, 4'b1111);
    step();
    st_valid = 1'b0;
    check("push_pop_count", {29'h0, count}, 32'd2);
    step();
    step();
    check("push_pop_drained", {29'h0, count}, 32'd0);

    // Two byte stores to the same word.
    mem_grant = 1'b0;
    drive(3'd0, 32'h40, 32'hAA);
    step();
    drive(3'd0, 32'h41, 32'hBB);
    step();
    st_valid = 1'b0;
`ifdef STBUF_MERGE_EN
    check("merge_count", {29'h0, count}, 32'd1);
    check("merge_upper_bytes", {16'h0, mem_data[31:16]}, 32'h0000AABB);
    expect_ent(32'h40, 32'hAABBAAAA, 4'b1100);
`else
    check("nomerge_count", {29'h0, count}, 32'd2);
    expect_ent(32'h40, 32'hAAAAAAAA, 4'b1000);
    expect_ent(32'h40, 32'hBBBBBBBB, 4'b0100);
`endif
    mem_grant = 1'b1;
    step();
    step();
    step();
    check("merge_seq_drained", {29'h0, count}, 32'd0);

    // Asynchronous reset in the middle of a drain discards pending stores.
    mem_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3'd2, 32'h700 + 32'(4 * i), 32'hC0 + 32'(i));
      expect_ent(32'h700 + 32'(4 * i), 32'hC0 + 32'(i), 4'b1111);
      step();
    end
    st_valid = 1'b0;
    check("pre_reset_count", {29'h0, count}, 32'd3);
    ld_addr = 32'h704;
    mem_grant = 1'b1;
    #1;
    check("pre_reset_conflict", {31'h0, ld_conflict}, 32'h1);
    check("pre_reset_mem_we", {28'h0, mem_we}, 32'hF);
    rst = 1'b1;
    #1;
    check("async_reset_count", {29'h0, count}, 32'd0);
    check("async_reset_mem_we", {28'h0, mem_we}, 32'h0);
    check("async_reset_st_ready", {31'h0, st_ready}, 32'h1);
    check("async_reset_mem_addr", mem_addr, 32'h0);
    check("async_reset_conflict", {31'h0, ld_conflict}, 32'h0);
    sb_q.delete();
    mem_grant = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("post_reset_count", {29'h0, count}, 32'd0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
